// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V constants for the fetch slice (NOP, XLEN, opcodes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, redirect and decode handshakes of fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, id_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO with flush; occupancy from wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_flush,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_din,
    input  wire logic                   i_pop,
    output logic      [WIDTH-1:0]       o_dout,
    output logic      [$clog2(DEPTH):0] o_count,
    output logic                        o_full,
    output logic                        o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;

    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_wptr == r_rptr);
    assign o_dout  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (i_pop)  r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy pointers gate every read.
    always_ff @(posedge clk) begin
        if (rst && !i_flush && i_push) r_mem[r_wptr[c_AW-1:0]] <= i_din;
    end
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC, credit-based imem requests, redirect drop and decode queue.
//               Optional counters enabled by macro FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fetch_unit_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_drop_cnt
`endif
);
    localparam int c_CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]    r_pc;
    logic [c_CW-1:0]    r_outstanding;
    logic [c_CW-1:0]    r_drop_cnt;
    logic [c_CW-1:0]    w_q_count;
    logic               w_q_full;
    logic               w_q_empty;
    logic [XLEN+31:0]   w_head;
    logic               w_credit;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_dec;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_rsp_pc;

    assign w_credit    = ({1'b0, r_outstanding} + {1'b0, w_q_count}) < (c_CW+1)'(QDEPTH);
    assign w_req_valid = rst && !bus.redirect_valid && w_credit;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_dec   = bus.imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop  = bus.imem_rsp_valid && (bus.redirect_valid || r_drop_cnt != '0);
    assign w_push      = bus.imem_rsp_valid && !w_rsp_drop;
    assign w_pop       = !w_q_empty && bus.id_ready && !bus.redirect_valid;

    // With no drops pending, every outstanding request was issued in sequence
    // up to pc-4, so the oldest one (the one returning now) sits at pc-4*outstanding.
    assign w_rsp_pc = r_pc - (XLEN'(r_outstanding) << 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CW'(w_req_fire) - c_CW'(w_rsp_dec);
            if (bus.redirect_valid) begin
                r_pc       <= bus.redirect_pc;
                r_drop_cnt <= r_outstanding - c_CW'(w_rsp_dec);
            end else begin
                if (w_req_fire) r_pc <= r_pc + XLEN'(4);
                if (bus.imem_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !bus.redirect_valid) assert (!(w_push && w_q_full && !w_pop));
    end

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_din   ({bus.imem_rsp_data, w_rsp_pc}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.id_valid       = !w_q_empty;
    assign bus.id_inst        = w_q_empty ? NOP_INST : w_head[XLEN+31:XLEN];
    assign bus.id_pc          = w_head[XLEN-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;
    logic [32:0] w_drop_sum;

    // Flushed entries and a dropped response can land in the same cycle.
    assign w_drop_sum = {1'b0, r_perf_drop}
                      + 33'(bus.redirect_valid ? w_q_count : '0)
                      + 33'(w_rsp_drop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_pop && r_perf_fetch != '1) r_perf_fetch <= r_perf_fetch + 32'd1;
            r_perf_drop <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;
`endif
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a latency-programmable imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];
    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cyc   = 0;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return a ^ 32'hA5A50001;
    endfunction

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: in-order responses 'lat' cycles after acceptance.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memdata(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
    end

    // Scoreboard: accepted requests push expectations, decode pops compare.
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            exp_q.delete();
            mem_q.delete();
        end else begin
            if (!bus.id_valid) begin
                total++;
                if (bus.id_inst !== NOP_INST) begin
                    bad++;
                    $display("FAIL idle_nop: id_inst=%h required=%h", bus.id_inst, NOP_INST);
                end
            end
            if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                exp_t e;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: id_pc=%h id_inst=%h required=none", bus.id_pc, bus.id_inst);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.id_pc !== e.pc || bus.id_inst !== e.inst) begin
                        bad++;
                        $display("FAIL sb_pop: pc=%h inst=%h required pc=%h inst=%h",
                                 bus.id_pc, bus.id_inst, e.pc, e.inst);
                    end
                end
            end
            if (bus.redirect_valid) exp_q.delete();
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                exp_q.push_back('{pc: bus.imem_req_addr, inst: memdata(bus.imem_req_addr)});
                mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            end
        end
    end

    task automatic test_reset();
        repeat (3) sample();
        total++;
        if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid: got=%b required=0", bus.id_valid); end
        total++;
        if (bus.id_inst !== NOP_INST) begin bad++; $display("FAIL reset_id_inst: got=%h required=%h", bus.id_inst, NOP_INST); end
        total++;
        if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got=%b required=0", bus.imem_req_valid); end
        total++;
        if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_pc: got=%h required=0", bus.imem_req_addr); end
        drive();
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        int n;
        exp_addr = 32'h0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                total++;
                if (bus.imem_req_addr !== exp_addr) begin
                    bad++;
                    $display("FAIL seq_addr: got=%h required=%h", bus.imem_req_addr, exp_addr);
                end
                exp_addr += 32'd4;
                n++;
            end
        end
        total++;
        if (n < 10) begin bad++; $display("FAIL seq_rate: accepts=%0d required>=10", n); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = 32'h0;
        drive();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i == 4) held = bus.imem_req_addr;
        end
        total++;
        if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req: got=%b required=0", bus.imem_req_valid); end
        total++;
        if (bus.imem_req_addr !== held) begin bad++; $display("FAIL stall_pc: got=%h required=%h", bus.imem_req_addr, held); end
        total++;
        if (u_dut.u_fifo.o_count !== 2'd2) begin bad++; $display("FAIL stall_count: got=%0d required=2", u_dut.u_fifo.o_count); end
        drive();
        bus.id_ready = 1'b1;
        repeat (6) sample();
    endtask

    task automatic test_redirect();
        int acc;
        logic [31:0] a0;
        logic [31:0] a1;
        logic seen;
        acc = 0; a0 = 32'h0; a1 = 32'h0; seen = 1'b0;
        lat = 3;
        drive();
        bus.imem_req_ready = 1'b0;
        repeat (5) sample();
        drive();
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h10;
        drive();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && acc < 2; i++) begin
            sample();
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (acc == 0) a0 = bus.imem_req_addr; else a1 = bus.imem_req_addr;
                acc++;
            end
        end
        total++;
        if (a0 !== 32'h10 || a1 !== 32'h14) begin
            bad++;
            $display("FAIL redir_inflight: addrs=%h,%h required=10,14", a0, a1);
        end
        drive();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        drive();
        bus.redirect_valid = 1'b0;
        sample();
        total++;
        if (u_dut.r_drop_cnt !== 2'd2) begin bad++; $display("FAIL redir_drop_cnt: got=%0d required=2", u_dut.r_drop_cnt); end
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.id_valid) seen = 1'b1; else sample();
        end
        total++;
        if (!seen || bus.id_pc !== 32'h100) begin
            bad++;
            $display("FAIL redir_target: seen=%b id_pc=%h required=00000100", seen, bus.id_pc);
        end
        repeat (6) sample();
    endtask

    task automatic test_redirect_collide();
        logic found;
        int exp_drop;
        found = 1'b0; exp_drop = 0;
        lat = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            sample();
            if (bus.imem_rsp_valid && bus.id_valid && bus.id_ready) begin
                exp_drop = mem_q.size();
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h200;
                found = 1'b1;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL collide_setup: found=0 required=1"); end
        drive();
        bus.redirect_valid = 1'b0;
        sample();
        total++;
        if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL collide_flush: id_valid=%b required=0", bus.id_valid); end
        total++;
        if (int'(u_dut.r_drop_cnt) != exp_drop) begin
            bad++;
            $display("FAIL collide_drop_cnt: got=%0d required=%0d", u_dut.r_drop_cnt, exp_drop);
        end
        repeat (8) sample();
    endtask

    task automatic test_wrap();
        int acc;
        logic [31:0] a0;
        logic [31:0] a1;
        acc = 0; a0 = 32'h0; a1 = 32'h1;
        drive();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        drive();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && acc < 2; i++) begin
            sample();
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (acc == 0) a0 = bus.imem_req_addr; else a1 = bus.imem_req_addr;
                acc++;
            end
        end
        total++;
        if (a0 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first: got=%h required=fffffffc", a0); end
        total++;
        if (a1 !== 32'h0) begin bad++; $display("FAIL wrap_next: got=%h required=00000000", a1); end
        repeat (8) sample();
    endtask

    task automatic test_reset_mid();
        drive();
        bus.id_ready = 1'b0;
        repeat (6) sample();
        drive();
        rst = 1'b0;
        drive();
        rst = 1'b1;
        sample();
        total++;
        if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_id_valid: got=%b required=0", bus.id_valid); end
        total++;
        if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_mid_pc: got=%h required=0", bus.imem_req_addr); end
`ifdef FETCH_PERF_EN
        total++;
        if (perf_fetch_cnt !== 32'h0) begin bad++; $display("FAIL rst_perf_fetch: got=%0d required=0", perf_fetch_cnt); end
        total++;
        if (perf_drop_cnt !== 32'h0) begin bad++; $display("FAIL rst_perf_drop: got=%0d required=0", perf_drop_cnt); end
`endif
        drive();
        bus.id_ready = 1'b1;
        repeat (12) sample();
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
